cic_decim_ctrl: RTL and testbench
=================================

# cic_decim_ctrl

Sequencing controller for the CIC decimation chain (three cascaded integrators feeding the comb section). It gates the integrators on valid input samples and counts input samples to produce the decimation strobe for the comb stage. It discards the comb warm-up outputs after a restart and presents decimated samples downstream with a valid/ready handshake and a sticky overrun flag. It sits between the modulator sample strobe and the integrator/comb datapath; it holds no data itself.

## Interface
- RATIO_W, 8, width of decimation ratio field
- ORDER, 3, CIC order = number of comb outputs discarded after restart
- DEFAULT_RATIO, 16, ratio loaded at reset
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- enable  in  1  level; 1 = run chain, 0 = return to IDLE
- cfg_ratio  in  RATIO_W  decimation ratio R
- cfg_load  in  1  load cfg_ratio (honoured in IDLE only)
- in_valid  in  1  one-cycle strobe per input sample
- out_ready  in  1  downstream accepts the comb output
- int_en  out  1  integrator advance enable
- int_clr  out  1  synchronous clear to integrators and comb delay lines
- comb_en  out  1  decimation strobe to the comb stage
- out_valid  out  1  comb output register holds an unread sample
- overrun  out  1  sticky: a decimated sample was lost
- busy  out  1  state != IDLE
- state  out  2  current FSM state (debug)

## Operation
- FSM states: IDLE=0, CLEAR=1, WARM=2, RUN=3.
  - IDLE -> CLEAR when enable=1.
  - CLEAR -> WARM unconditionally after 1 cycle.
  - WARM -> RUN on the ORDER-th comb_en.
  - Any state -> IDLE when enable=0, taking priority over all other transitions.
- int_clr = 1 in IDLE and CLEAR; 0 otherwise.
- int_en = in_valid while state is WARM or RUN. It is combinational, so the integrators consume the sample on the same edge.
- Phase counter: 0..R-1. It increments on int_en and wraps to 0 from R-1. It is cleared in IDLE and CLEAR.
- comb_en is a registered one-cycle pulse. It is asserted the cycle after an int_en that occurs with phase = R-1.
- Ratio register:
  - Loaded from cfg_ratio when cfg_load=1 in IDLE. cfg_load in any other state is ignored.
  - Values 0 and 1 are clamped to 2.
  - Reset value: DEFAULT_RATIO.
- Warm-up counter counts comb_en pulses in WARM. out_valid is never set in WARM.
- out_valid:
  - Set on the edge where comb_en=1 in RUN.
  - Cleared on the edge where out_valid=1 and out_ready=1, unless a new comb_en arrives on the same edge. In that case it stays 1 and no overrun is raised.
- overrun: set when comb_en=1 in RUN while out_valid=1 and out_ready=0. Cleared only in CLEAR.
- enable=0 in any state: next cycle state=IDLE, out_valid=0, phase=0, comb_en=0, and int_clr asserts. overrun is kept.

## Timing
- Reset values: state=IDLE, int_en=0, int_clr=1, comb_en=0, out_valid=0, overrun=0, busy=0, ratio=DEFAULT_RATIO.
- Enable to first integration: enable rising at cycle t gives CLEAR at t+1 and WARM at t+2. in_valid is first honoured at t+2.
- Strobe latency: the R-th sample at cycle s gives comb_en at s+1 and out_valid at s+2.
- Steady state: one comb_en per R in_valid strobes. Gaps in in_valid stretch the period; they do not reset the phase.
- First out_valid after restart: the (ORDER+1)-th decimation point, i.e. after (ORDER+1)*R input samples.
- in_valid on the same cycle as the CLEAR->WARM transition is ignored (int_en=0 in CLEAR).
- enable=0 on the same cycle as a pending comb_en: the comb_en is dropped and out_valid is not set.

## Structure
- cic_pkg holds the state typedef (IDLE/CLEAR/WARM/RUN), the ORDER default and the RATIO_W default. The comb and integrator blocks share it.
- Sub-module decim_phase_counter: the phase counter with ratio register, clamp and the wrap pulse. The FSM, warm-up counter and handshake logic stay in cic_decim_ctrl.

## Test plan
- Reset, then idle: all outputs hold their reset values; int_clr=1; state=0.
- Load R=4 in IDLE, enable, in_valid every cycle: comb_en pulses every 4 cycles; first out_valid appears 2 cycles after the 16th sample; out_ready=1 gives one out_valid pulse per 4 samples.
- R=4 with out_ready=0 after the first output: out_valid stays 1; at the next comb_en, overrun=1 and stays 1. Dropping and reasserting enable clears overrun at CLEAR.
- cfg_ratio=1 with cfg_load in IDLE: ratio clamps to 2 and comb_en pulses every 2 samples. cfg_load=1 with cfg_ratio=8 during RUN is ignored and the period stays 2.
- Deassert enable in RUN with phase=2: next cycle state=IDLE, out_valid=0, int_clr=1. Re-enable gives a full warm-up of ORDER discarded outputs before the next out_valid.
- out_ready=1 on the same cycle as a new comb_en with R=2: out_valid stays 1 and overrun stays 0.

Source files
------------

// File: rtl/cic_pkg.sv
// Shared definitions for the CIC decimation chain: controller state encoding
// and default chain parameters.
package cic_pkg;

  localparam int RATIO_W_DEF = 8;
  localparam int ORDER_DEF   = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_WARM  = 2'd2,
    ST_RUN   = 2'd3
  } cic_state_t;

endpackage

// File: rtl/decim_phase_counter.sv
// Decimation phase counter: holds the ratio register (clamped to >= 2) and
// counts integrated samples 0..R-1, pulsing wrap on the last sample of a period.
module decim_phase_counter #(
  parameter int RATIO_W       = 8,
  parameter int DEFAULT_RATIO = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [RATIO_W-1:0] cfg_ratio,
  input  logic               load,
  input  logic               clr,
  input  logic               advance,
  output logic               wrap
);

  localparam logic [RATIO_W-1:0] MIN_RATIO = RATIO_W'(2);
  localparam logic [RATIO_W-1:0] ONE       = RATIO_W'(1);

  logic [RATIO_W-1:0] ratio;
  logic [RATIO_W-1:0] phase;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ratio <= RATIO_W'(DEFAULT_RATIO);
    end else if (load) begin
      ratio <= (cfg_ratio < MIN_RATIO) ? MIN_RATIO : cfg_ratio;
    end
  end

  assign wrap = advance && (phase == ratio - ONE);

  // Gaps in advance only stretch the period; the phase is never lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= '0;
    end else if (clr) begin
      phase <= '0;
    end else if (advance) begin
      phase <= wrap ? '0 : phase + ONE;
    end
  end

endmodule

// File: rtl/cic_decim_ctrl.sv
// Sequencing controller for the CIC decimator: gates integrators, generates the
// comb decimation strobe, discards comb warm-up outputs and handshakes results.
module cic_decim_ctrl
  import cic_pkg::*;
#(
  parameter int RATIO_W       = RATIO_W_DEF,
  parameter int ORDER         = ORDER_DEF,
  parameter int DEFAULT_RATIO = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [RATIO_W-1:0] cfg_ratio,
  input  logic               cfg_load,
  input  logic               in_valid,
  input  logic               out_ready,
  output logic               int_en,
  output logic               int_clr,
  output logic               comb_en,
  output logic               out_valid,
  output logic               overrun,
  output logic               busy,
  output logic [1:0]         state
);

  localparam int WARM_W = (ORDER < 1) ? 1 : $clog2(ORDER + 1);
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(ORDER - 1);
  localparam logic [WARM_W-1:0] WARM_ONE  = WARM_W'(1);

  cic_state_t cur_state, nxt_state;
  logic              wrap;
  logic              chain_clr;
  logic [WARM_W-1:0] warm_cnt;
  logic              warm_done;

  assign int_clr   = (cur_state == ST_IDLE) || (cur_state == ST_CLEAR);
  assign int_en    = in_valid && ((cur_state == ST_WARM) || (cur_state == ST_RUN));
  assign busy      = (cur_state != ST_IDLE);
  assign state     = cur_state;
  // Dropping enable clears the datapath on the very next edge, not one later.
  assign chain_clr = int_clr || !enable;
  assign warm_done = comb_en && (warm_cnt == WARM_LAST);

  decim_phase_counter #(
    .RATIO_W       (RATIO_W),
    .DEFAULT_RATIO (DEFAULT_RATIO)
  ) u_phase (
    .clk       (clk),
    .rst       (rst),
    .cfg_ratio (cfg_ratio),
    .load      (cfg_load && (cur_state == ST_IDLE)),
    .clr       (chain_clr),
    .advance   (int_en),
    .wrap      (wrap)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cur_state <= ST_IDLE;
    else     cur_state <= nxt_state;
  end

  always_comb begin
    nxt_state = cur_state;
    if (!enable) begin
      nxt_state = ST_IDLE;
    end else begin
      case (cur_state)
        ST_IDLE:  nxt_state = ST_CLEAR;
        ST_CLEAR: nxt_state = ST_WARM;
        ST_WARM:  if (warm_done) nxt_state = ST_RUN;
        default:  nxt_state = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      comb_en  <= 1'b0;
      warm_cnt <= '0;
    end else begin
      comb_en <= wrap && enable;
      if (chain_clr)
        warm_cnt <= '0;
      else if (comb_en && (cur_state == ST_WARM))
        warm_cnt <= warm_cnt + WARM_ONE;
    end
  end

  // Handshake: out_valid marks an unread comb output; it is consumed on any edge
  // where out_valid && out_ready. A comb_en in RUN reloads it on the same edge,
  // and a comb_en that meets an unconsumed sample (out_ready=0) flags overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (!enable) begin
      out_valid <= 1'b0;
    end else begin
      if (comb_en && (cur_state == ST_RUN))
        out_valid <= 1'b1;
      else if (out_valid && out_ready)
        out_valid <= 1'b0;

      if (cur_state == ST_CLEAR)
        overrun <= 1'b0;
      else if (comb_en && (cur_state == ST_RUN) && out_valid && !out_ready)
        overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cic_decim_ctrl.sv
// Self-checking bench for cic_decim_ctrl against a sample-count reference model.
module tb_cic_decim_ctrl;

  localparam int RATIO_W = 8;
  localparam int ORDER   = 3;
  localparam int DEF_R   = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic               enable;
  logic [RATIO_W-1:0] cfg_ratio;
  logic               cfg_load;
  logic               in_valid;
  logic               out_ready;
  logic               int_en;
  logic               int_clr;
  logic               comb_en;
  logic               out_valid;
  logic               overrun;
  logic               busy;
  logic [1:0]         state;

  int checks   = 0;
  int failures = 0;

  // Reference model: mode 0..3, samples integrated since restart, decimation
  // points reached since restart, pending comb strobe, handshake flags.
  int m_mode    = 0;
  int m_ratio   = DEF_R;
  int m_samples = 0;
  int m_points  = 0;
  bit m_comb    = 1'b0;
  bit m_valid   = 1'b0;
  bit m_overrun = 1'b0;

  cic_decim_ctrl #(
    .RATIO_W       (RATIO_W),
    .ORDER         (ORDER),
    .DEFAULT_RATIO (DEF_R)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .cfg_ratio (cfg_ratio),
    .cfg_load  (cfg_load),
    .in_valid  (in_valid),
    .out_ready (out_ready),
    .int_en    (int_en),
    .int_clr   (int_clr),
    .comb_en   (comb_en),
    .out_valid (out_valid),
    .overrun   (overrun),
    .busy      (busy),
    .state     (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic check_outputs(input bit iv);
    check("state",     32'(state),     32'(m_mode));
    check("int_en",    32'(int_en),    32'(iv && m_mode >= 2));
    check("int_clr",   32'(int_clr),   32'(m_mode <= 1));
    check("busy",      32'(busy),      32'(m_mode != 0));
    check("comb_en",   32'(comb_en),   32'(m_comb));
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("overrun",   32'(overrun),   32'(m_overrun));
  endtask

  // One clock: drive inputs, check outputs mid-cycle, advance model across the edge.
  task automatic step(input bit en, input bit ld, input int cr, input bit iv, input bit rdy);
    int n_mode, n_ratio, n_samples, n_points;
    bit n_comb, n_valid, n_overrun, sample_taken;
    enable    = en;
    cfg_load  = ld;
    cfg_ratio = RATIO_W'(cr);
    in_valid  = iv;
    out_ready = rdy;
    @(negedge clk);
    check_outputs(iv);

    n_ratio   = m_ratio;
    if (m_mode == 0 && ld) n_ratio = (cr < 2) ? 2 : cr;
    n_mode    = m_mode;
    n_samples = m_samples;
    n_points  = m_points;
    n_comb    = 1'b0;
    n_valid   = m_valid;
    n_overrun = m_overrun;
    sample_taken = iv && m_mode >= 2;

    if (!en) begin
      n_mode = 0; n_samples = 0; n_points = 0; n_valid = 1'b0;
    end else if (m_mode <= 1) begin
      n_mode = m_mode + 1; n_samples = 0; n_points = 0;
      if (m_mode == 1) n_overrun = 1'b0;
    end else begin
      if (sample_taken) begin
        n_samples = m_samples + 1;
        n_comb    = (n_samples % m_ratio) == 0;
      end
      if (m_comb) begin
        n_points = m_points + 1;
        if (m_mode == 2 && n_points == ORDER) n_mode = 3;
      end
      if (m_comb && m_mode == 3) begin
        if (m_valid && !rdy) n_overrun = 1'b1;
        n_valid = 1'b1;
      end else if (m_valid && rdy) begin
        n_valid = 1'b0;
      end
    end

    @(posedge clk);
    #1;
    m_mode = n_mode; m_ratio = n_ratio; m_samples = n_samples; m_points = n_points;
    m_comb = n_comb; m_valid = n_valid; m_overrun = n_overrun;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; cfg_ratio = '0; cfg_load = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs(1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    repeat (4) step(0, 0, 0, 0, 0);

    // R=4, continuous samples, consumer always ready
    step(0, 1, 4, 0, 1);
    repeat (60) step(1, 0, 0, 1, 1);

    // Consumer stalls: overrun must latch, then survive disable, clear at CLEAR
    repeat (20) step(1, 0, 0, 1, 0);
    repeat (2) step(0, 0, 0, 0, 0);
    repeat (10) step(1, 0, 0, 1, 1);

    // Gapped samples stretch the period
    repeat (60) step(1, 0, 0, 1'($urandom_range(0, 1)), 1);

    // Disable in RUN at phase 2, then full warm-up again
    step(0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 1, 1);
    repeat (18) step(1, 0, 0, 1, 1);
    step(0, 0, 0, 1, 1);
    repeat (30) step(1, 0, 0, 1, 1);

    // Ratio 1 clamps to 2; load during RUN ignored; ready on comb edges
    step(0, 0, 0, 0, 1);
    step(0, 1, 1, 0, 1);
    repeat (20) step(1, 0, 0, 1, 1);
    step(1, 1, 8, 1, 1);
    repeat (20) step(1, 0, 0, 1, 1);
    repeat (30) step(1, 0, 0, 1, 1'($urandom_range(0, 1)));

    // Random stress
    for (int i = 0; i < 2000; i++) begin
      step(1'($urandom_range(0, 49) != 0), 1'($urandom_range(0, 3) == 0),
           int'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 2) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
